clkdiv_burst: RTL and testbench
===============================

// Module: clkdiv_burst
//
// PURPOSE
//  Runtime-programmable clock divider that emits a burst of N output clock periods on request.
//  It generates serial clocks (SPI SCLK, I2C SCL) for protocol engines that need an exact edge count and edge strobes.
//  Sits between a protocol FSM (drives start_i, samples on lead_o/trail_o) and the pad.
//  Guarantees no clk_o phase is shorter than the programmed half period, including the first and last phases.
//
// PARAMETERS
//  HALF_WIDTH   8   width of half_i; max half period 2**HALF_WIDTH-1 clk_i cycles
//  COUNT_WIDTH  8   width of ncycles_i; max burst 2**COUNT_WIDTH-1 periods
//  IDLE_HIGH    1   1: clk_o idles high (active phase low); 0: idles low
//
// PORTS
//  clk_i      in   1            system clock
//  rst_ni     in   1            asynchronous active-low reset
//  start_i    in   1            request burst; accepted only when busy_o==0
//  half_i     in   HALF_WIDTH   half period in clk_i cycles, latched on accept; 0 treated as 1
//  ncycles_i  in   COUNT_WIDTH  number of clk_o periods, latched on accept
//  abort_i    in   1            finish current period then stop
//  clk_o      out  1            divided clock, registered
//  busy_o     out  1            burst in progress
//  lead_o     out  1            1-cycle pulse, same cycle clk_o leaves idle level
//  trail_o    out  1            1-cycle pulse, same cycle clk_o returns to idle level
//  done_o     out  1            1-cycle pulse, burst complete
//
// BEHAVIOUR
//  Reset (async, rst_ni low): clk_o=IDLE_HIGH, all other outputs 0, state IDLE, counters 0; mid-burst reset drops immediately, no done_o.
//  Latch: half_q and ncycles_q are captured on accept; input changes while busy_o=1 are ignored.
//  start_i while busy_o=1 is ignored.
//  States:
//   IDLE: clk_o=idle. Accept start_i in cycle T:
//    ncycles_i!=0: at T+1 busy_o=1, clk_o=active, lead_o=1, go ACTIVE.
//    ncycles_i==0: done_o=1 at T+1; busy_o stays 0; clk_o never toggles.
//   ACTIVE: hold clk_o active for H=max(half_q,1) cycles, counting the lead cycle.
//    Then clk_o=idle with trail_o=1, period_cnt++, go INACTIVE.
//   INACTIVE: hold clk_o idle for H cycles, counting the trail cycle.
//    Then, if period_cnt<ncycles_q and no abort pending: clk_o=active, lead_o=1, go ACTIVE.
//    Otherwise: go IDLE, busy_o=0, done_o=1 in that same cycle.
//  Period = 2*H clk_i cycles, 50% duty.
//  Final INACTIVE phase is the cooldown: clk_o stays idle >=H cycles after the last trailing edge before the next lead edge.
//  Back-to-back: start_i sampled in the done_o cycle is accepted.
//   Its lead edge comes the next cycle, so the idle gap is H+1 cycles.
//  abort_i: sampled any cycle while busy_o=1 and sets a sticky abort_pending.
//   The current period completes normally (full ACTIVE and INACTIVE), then done_o.
//   abort_pending clears on done_o. abort_i is ignored when busy_o=0.
//  Widths:
//   Half counter is HALF_WIDTH bits, compared against H-1; no wrap.
//   period_cnt is COUNT_WIDTH bits; it cannot wrap because ncycles_q<=2**COUNT_WIDTH-1.
//  Pulses: lead_o and trail_o never assert in the same cycle; done_o never coincides with lead_o.
//  Edge counts: lead_o count == trail_o count == periods emitted.
//   Periods emitted = ncycles_q, or fewer on abort.
//
// TESTING
//  1. Reset, IDLE_HIGH=1: start_i at T, half_i=3, ncycles_i=4.
//     -> clk_o low T+1..T+3, high T+4..T+6, repeated 4x; 4 lead_o, 4 trail_o.
//     -> done_o and busy_o fall at T+25.
//  2. half_i=0, ncycles_i=2 -> treated as H=1: clk_o toggles every cycle, 2 periods, done_o at T+5.
//  3. ncycles_i=0 -> done_o at T+1 only; busy_o, clk_o, lead_o and trail_o unchanged.
//  4. half_i=4, ncycles_i=10, abort_i pulsed mid-ACTIVE of period 3.
//     -> period 3 completes in full, exactly 3 trail_o pulses, done_o after the 4-cycle cooldown.
//  5. Back-to-back: start_i held high, half_i=2, ncycles_i=1 -> second lead_o 1 cycle after done_o.
//     -> no clk_o phase <2 cycles; half_i changes during busy_o have no effect.
//  6. rst_ni low mid-ACTIVE (IDLE_HIGH=0) -> clk_o=0 and busy_o=0 asynchronously, no done_o.
//     -> the next start_i behaves like a fresh burst.

Source files
------------

// File: rtl/clkdiv_burst.sv
// Burst clock divider: emits ncycles periods of a 2*H-cycle, 50% duty clock on
// request, with lead/trail edge strobes and a done pulse after a full-H cooldown.
//
//   state       | meaning
//   ST_IDLE     | clk_o at idle level, waiting for start_i
//   ST_ACTIVE   | clk_o at active level for H cycles (lead cycle included)
//   ST_INACTIVE | clk_o at idle level for H cycles (trail cycle included)
module clkdiv_burst #(
  parameter int HALF_WIDTH  = 8,
  parameter int COUNT_WIDTH = 8,
  parameter bit IDLE_HIGH   = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [HALF_WIDTH-1:0]  half_i,
  input  logic [COUNT_WIDTH-1:0] ncycles_i,
  input  logic                   abort_i,
  output logic                   clk_o,
  output logic                   busy_o,
  output logic                   lead_o,
  output logic                   trail_o,
  output logic                   done_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_INACTIVE} state_t;

  localparam logic                   CLK_IDLE   = IDLE_HIGH;
  localparam logic                   CLK_ACTIVE = !IDLE_HIGH;
  localparam logic [HALF_WIDTH-1:0]  HALF_ONE   = 1;
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE  = 1;

  state_t                 state_q;
  logic [HALF_WIDTH-1:0]  half_q;
  logic [HALF_WIDTH-1:0]  half_cnt_q;
  logic [COUNT_WIDTH-1:0] ncycles_q;
  logic [COUNT_WIDTH-1:0] period_cnt_q;
  logic                   abort_pending_q;
  logic                   phase_end;
  logic                   stop_burst;

  // half_q is never 0 (0 is latched as 1), so half_q-1 cannot wrap
  assign phase_end  = (half_cnt_q == (half_q - HALF_ONE));
  // an abort seen in the very last cooldown cycle still ends this burst
  assign stop_burst = !(period_cnt_q < ncycles_q) || abort_pending_q || abort_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= ST_IDLE;
      half_q          <= '0;
      half_cnt_q      <= '0;
      ncycles_q       <= '0;
      period_cnt_q    <= '0;
      abort_pending_q <= 1'b0;
      clk_o           <= CLK_IDLE;
      busy_o          <= 1'b0;
      lead_o          <= 1'b0;
      trail_o         <= 1'b0;
      done_o          <= 1'b0;
    end else begin
      lead_o  <= 1'b0;
      trail_o <= 1'b0;
      done_o  <= 1'b0;
      if (busy_o && abort_i) abort_pending_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            half_q          <= (half_i == '0) ? HALF_ONE : half_i;
            ncycles_q       <= ncycles_i;
            half_cnt_q      <= '0;
            period_cnt_q    <= '0;
            abort_pending_q <= 1'b0;
            if (ncycles_i != '0) begin
              state_q <= ST_ACTIVE;
              clk_o   <= CLK_ACTIVE;
              busy_o  <= 1'b1;
              lead_o  <= 1'b1;
            end else begin
              done_o <= 1'b1;
            end
          end
        end

        ST_ACTIVE: begin
          if (phase_end) begin
            half_cnt_q   <= '0;
            clk_o        <= CLK_IDLE;
            trail_o      <= 1'b1;
            period_cnt_q <= period_cnt_q + COUNT_ONE;
            state_q      <= ST_INACTIVE;
          end else begin
            half_cnt_q <= half_cnt_q + HALF_ONE;
          end
        end

        ST_INACTIVE: begin
          if (phase_end) begin
            half_cnt_q <= '0;
            if (stop_burst) begin
              state_q         <= ST_IDLE;
              busy_o          <= 1'b0;
              done_o          <= 1'b1;
              abort_pending_q <= 1'b0;
            end else begin
              clk_o   <= CLK_ACTIVE;
              lead_o  <= 1'b1;
              state_q <= ST_ACTIVE;
            end
          end else begin
            half_cnt_q <= half_cnt_q + HALF_ONE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          clk_o   <= CLK_IDLE;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clkdiv_burst.sv
// Bench for clkdiv_burst: two instances (idle-high and idle-low) share stimulus and
// are compared every cycle against an arithmetic schedule model of the burst.
module tb_clkdiv_burst;
  localparam int HW = 8;
  localparam int CW = 8;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b1;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic [HW-1:0] half_i = '0;
  logic [CW-1:0] ncycles_i = '0;

  logic clk_h, busy_h, lead_h, trail_h, done_h;
  logic clk_l, busy_l, lead_l, trail_l, done_l;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic chk_en = 1'b0;
  int lead_cnt = 0, trail_cnt = 0, done_cnt = 0;

  clkdiv_burst #(.HALF_WIDTH(HW), .COUNT_WIDTH(CW), .IDLE_HIGH(1'b1)) u_dut_h (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .half_i(half_i),
    .ncycles_i(ncycles_i), .abort_i(abort_i), .clk_o(clk_h), .busy_o(busy_h),
    .lead_o(lead_h), .trail_o(trail_h), .done_o(done_h));

  clkdiv_burst #(.HALF_WIDTH(HW), .COUNT_WIDTH(CW), .IDLE_HIGH(1'b0)) u_dut_l (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .half_i(half_i),
    .ncycles_i(ncycles_i), .abort_i(abort_i), .clk_o(clk_l), .busy_o(busy_l),
    .lead_o(lead_l), .trail_o(trail_l), .done_o(done_l));

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Model: a burst accepted in cycle T starts at t0=T+1; offset k=cyc-t0 gives
  // active when k mod 2H < H, lead at k mod 2H == 0, trail at k mod 2H == H,
  // done at k == 2H*P where P is ncycles or (aborted period index + 1).
  logic m_busy = 1'b0;
  int   m_t0 = 0, m_h = 1, m_per = 0;
  logic e_act = 1'b0, e_busy = 1'b0, e_lead = 1'b0, e_trail = 1'b0, e_done = 1'b0;

  logic n_busy, n_act, n_lead, n_trail, n_done;
  int   n_t0, n_h, n_per, k, p;

  always_comb begin
    n_busy = m_busy; n_t0 = m_t0; n_h = m_h; n_per = m_per;
    n_act = 1'b0; n_lead = 1'b0; n_trail = 1'b0; n_done = 1'b0;
    k = 0; p = 0;
    if (m_busy && abort_i) begin
      p = (cyc - m_t0) / (2 * m_h);
      if (p + 1 < n_per) n_per = p + 1;
    end
    if (m_busy) begin
      k = cyc + 1 - m_t0;
      if (k == 2 * m_h * n_per) begin
        n_done = 1'b1;
        n_busy = 1'b0;
      end else begin
        n_act   = (k % (2 * m_h)) < m_h;
        n_lead  = (k % (2 * m_h)) == 0;
        n_trail = (k % (2 * m_h)) == m_h;
      end
    end else if (start_i) begin
      if (ncycles_i != '0) begin
        n_busy = 1'b1;
        n_t0   = cyc + 1;
        n_h    = (half_i == '0) ? 1 : int'(half_i);
        n_per  = int'(ncycles_i);
        n_act  = 1'b1;
        n_lead = 1'b1;
      end else begin
        n_done = 1'b1;
      end
    end
  end

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_busy <= 1'b0; e_act <= 1'b0; e_busy <= 1'b0;
      e_lead <= 1'b0; e_trail <= 1'b0; e_done <= 1'b0;
    end else begin
      m_busy <= n_busy; m_t0 <= n_t0; m_h <= n_h; m_per <= n_per;
      e_act <= n_act; e_busy <= n_busy; e_lead <= n_lead;
      e_trail <= n_trail; e_done <= n_done;
    end
  end

  always @(negedge clk_i) begin
    if (chk_en) begin
      check("clk_h", clk_h, !e_act);
      check("clk_l", clk_l, e_act);
      check("busy_h", busy_h, e_busy);
      check("busy_l", busy_l, e_busy);
      check("lead_h", lead_h, e_lead);
      check("lead_l", lead_l, e_lead);
      check("trail_h", trail_h, e_trail);
      check("trail_l", trail_l, e_trail);
      check("done_h", done_h, e_done);
      check("done_l", done_l, e_done);
      if (lead_h) lead_cnt++;
      if (trail_h) trail_cnt++;
      if (done_h) done_cnt++;
    end
  end

  task automatic wait_done(input int maxc, output int dcyc);
    dcyc = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk_i);
      if (done_h) begin
        dcyc = cyc;
        break;
      end
    end
    check("done_seen", int'(dcyc >= 0), 1);
  endtask

  task automatic launch(input int h, input int n, output int t);
    @(negedge clk_i);
    half_i = HW'(h); ncycles_i = CW'(n); start_i = 1'b1;
    t = cyc;
  endtask

  initial begin
    int t, d, l0, tr0, d0;
    #2 rst_ni = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;

    // 1: H=3, 4 periods, done at T+25
    launch(3, 4, t); l0 = lead_cnt; tr0 = trail_cnt;
    @(negedge clk_i); start_i = 1'b0;
    check("t1_first_lead", lead_h, 1);
    check("t1_clk_low", clk_h, 0);
    repeat (3) @(negedge clk_i);
    check("t1_first_trail", trail_h, 1);
    check("t1_clk_high", clk_h, 1);
    wait_done(40, d);
    check("t1_done_cyc", d - t, 25);
    check("t1_busy_fall", busy_h, 0);
    #1;
    check("t1_leads", lead_cnt - l0, 4);
    check("t1_trails", trail_cnt - tr0, 4);

    // 2: half 0 acts as 1
    launch(0, 2, t); l0 = lead_cnt;
    @(negedge clk_i); start_i = 1'b0;
    wait_done(20, d);
    check("t2_done_cyc", d - t, 5);
    #1;
    check("t2_leads", lead_cnt - l0, 2);

    // 3: zero periods
    launch(5, 0, t);
    @(negedge clk_i); start_i = 1'b0;
    check("t3_done", done_h, 1);
    check("t3_busy", busy_h, 0);
    check("t3_clk", clk_h, 1);
    check("t3_lead", lead_h, 0);
    @(negedge clk_i);
    check("t3_done_once", done_h, 0);

    // 4: abort during active phase of period 3
    launch(4, 10, t); tr0 = trail_cnt;
    @(negedge clk_i); start_i = 1'b0;
    repeat (17) @(negedge clk_i);
    abort_i = 1'b1;
    @(negedge clk_i); abort_i = 1'b0;
    wait_done(60, d);
    check("t4_done_cyc", d - t, 25);
    #1;
    check("t4_trails", trail_cnt - tr0, 3);

    // 5: back-to-back with start held, inputs wiggled while busy
    launch(2, 1, t);
    @(negedge clk_i); check("t5_lead1", lead_h, 1);
    @(negedge clk_i); half_i = 8'd7; ncycles_i = 8'd9;
    @(negedge clk_i); check("t5_trail1", trail_h, 1);
    @(negedge clk_i); half_i = 8'd2; ncycles_i = 8'd1;
    @(negedge clk_i); check("t5_done1", done_h, 1);
    @(negedge clk_i); check("t5_lead2", lead_h, 1); start_i = 1'b0;
    wait_done(20, d);
    check("t5_done2_cyc", d - t, 10);

    // 6: async reset mid-active, then a fresh burst
    launch(5, 3, t);
    @(negedge clk_i); start_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    check("t6_clk_l_rst", clk_l, 0);
    check("t6_busy_l_rst", busy_l, 0);
    check("t6_clk_h_rst", clk_h, 1);
    d0 = done_cnt;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check("t6_no_done", done_cnt - d0, 0);
    launch(2, 2, t);
    @(negedge clk_i); start_i = 1'b0;
    check("t6_fresh_lead", lead_l, 1);
    check("t6_fresh_clk", clk_l, 1);
    wait_done(20, d);
    check("t6_fresh_done", d - t, 9);

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk_i);
      start_i   = ($urandom % 3) == 0;
      half_i    = HW'($urandom_range(0, 6));
      ncycles_i = CW'($urandom_range(0, 5));
      abort_i   = ($urandom % 30) == 0;
    end
    @(negedge clk_i);
    start_i = 1'b0; abort_i = 1'b0;
    repeat (100) @(negedge clk_i);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
